// File: rtl/putch_tx_ctrl_pkg.sv
// Shared constants for the commit-side console output path.
package putch_tx_ctrl_pkg;
  localparam logic [6:0] PUTCH_OPCODE = 7'h7b;
  localparam int INST_W = 32;
  localparam int REG_W  = 64;
  localparam int CHAR_W = 8;
endpackage

// File: rtl/putch_tx_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on dout while !empty.
module sync_fifo_fwft #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;

  // Storage is intentionally not reset; contents are meaningless once count drops to zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign level = count;

endmodule

// File: rtl/putch_tx_ctrl.sv
// Captures retiring putch characters into a FIFO and drains them to a byte-wide console sink.
module putch_tx_ctrl
  import putch_tx_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallW,
  input  logic [INST_W-1:0] instW,
  input  logic [REG_W-1:0]  reg_a0,
  output logic              putch_stall,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [LW-1:0]     fifo_level,
  output logic [CNT_W-1:0]  tx_cnt
);

  logic is_putch;
  logic push;
  logic pop;
  logic empty;
  logic full;
  logic [CNT_W-1:0] tx_cnt_q;

  assign is_putch = (instW[6:0] == PUTCH_OPCODE);
  // A full FIFO refuses the push even if it pops this cycle; the held putch lands one cycle later.
  assign push        = is_putch & ~stallW & ~full;
  assign pop         = tx_valid & tx_ready;
  // Kept free of stallW/tx_ready so the hazard unit sees no combinational loop.
  assign putch_stall = is_putch & full;
  assign tx_valid    = ~empty;

  sync_fifo_fwft #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (reg_a0[DATA_W-1:0]),
    .dout  (tx_data),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst)      tx_cnt_q <= '0;
    else if (pop) tx_cnt_q <= tx_cnt_q + CNT_W'(1);
  end

  assign tx_cnt = tx_cnt_q;

endmodule

// File: tb/tb_putch_tx_ctrl.sv
// Directed bench for putch_tx_ctrl with a queue-based reference model checked every cycle.
module tb_putch_tx_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallW;
  logic [31:0] instW;
  logic [63:0] reg_a0;
  logic        putch_stall;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  fifo_level;
  logic [31:0] tx_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mq[$];
  logic [31:0] mcnt = '0;

  putch_tx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stallW      (stallW),
    .instW       (instW),
    .reg_a0      (reg_a0),
    .putch_stall (putch_stall),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .fifo_level  (fifo_level),
    .tx_cnt      (tx_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: occupancy is the queue length, the head is the next character out.
  always @(posedge clk) begin
    bit m_push, m_pop, m_putch;
    m_putch = (instW[6:0] == 7'h7b);
    m_push  = m_putch && !stallW && (mq.size() < DEPTH);
    m_pop   = (mq.size() > 0) && tx_ready;
    if (rst) begin
      mq.delete();
      mcnt = '0;
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
        mcnt = mcnt + 32'd1;
      end
      if (m_push) mq.push_back(reg_a0[7:0]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 64'(tx_valid), 64'(mq.size() != 0));
      chk("m_level", 64'(fifo_level), 64'(mq.size()));
      chk("m_cnt", 64'(tx_cnt), 64'(mcnt));
      chk("m_stall", 64'(putch_stall),
          64'((instW[6:0] == 7'h7b) && (mq.size() == DEPTH)));
      if (mq.size() != 0) chk("m_data", 64'(tx_data), 64'(mq[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stallW = 1'b0; instW = '0; reg_a0 = '0; tx_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_cnt", 64'(tx_cnt), 64'd0);
    chk("rst_stall", 64'(putch_stall), 64'd0);

    // single putch
    instW = 32'h0000_007b; reg_a0 = 64'h41; tx_ready = 1'b1;
    tick();
    instW = '0;
    chk("t1_valid", 64'(tx_valid), 64'd1);
    chk("t1_data", 64'(tx_data), 64'h41);
    tick();
    chk("t1_valid_drop", 64'(tx_valid), 64'd0);
    chk("t1_cnt", 64'(tx_cnt), 64'd1);
    chk("t1_level", 64'(fifo_level), 64'd0);

    // gating
    instW = 32'h7b; stallW = 1'b1; reg_a0 = 64'h50;
    tick();
    stallW = 1'b0; instW = '0;
    chk("t2_stallW", 64'(fifo_level), 64'd0);
    instW = 32'h33; reg_a0 = 64'h42;
    tick();
    chk("t2_opcode", 64'(fifo_level), 64'd0);
    instW = 32'h7b; reg_a0 = 64'hFFFF_FFFF_FFFF_FF42; tx_ready = 1'b0;
    tick();
    instW = '0;
    chk("t2_upper", 64'(tx_data), 64'h42);
    tx_ready = 1'b1;
    tick();
    chk("t2_cnt", 64'(tx_cnt), 64'd2);

    // full / back-pressure
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      instW = 32'h7b; reg_a0 = 64'(8'h61 + i);
      tick();
    end
    chk("t3_full", 64'(fifo_level), 64'd8);
    reg_a0 = 64'h69;
    #1;
    chk("t3_stall", 64'(putch_stall), 64'd1);
    tick();
    chk("t3_hold", 64'(fifo_level), 64'd8);
    chk("t3_head", 64'(tx_data), 64'h61);
    tx_ready = 1'b1;
    #1;
    chk("t3_stall_ready", 64'(putch_stall), 64'd1);
    tick();
    tx_ready = 1'b0;
    chk("t3_bubble", 64'(fifo_level), 64'd7);
    #1;
    chk("t3_stall_drop", 64'(putch_stall), 64'd0);
    tick();
    instW = '0;
    chk("t3_refill", 64'(fifo_level), 64'd8);
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_order", 64'(tx_data), 64'(8'h62 + k));
      tick();
    end
    chk("t3_empty", 64'(tx_valid), 64'd0);

    // simultaneous push/pop at level 3
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instW = 32'h7b; reg_a0 = 64'(8'h70 + i);
      tick();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reg_a0 = 64'(8'h73 + i);
      tick();
      chk("t4_level", 64'(fifo_level), 64'd3);
    end
    instW = '0;
    for (int i = 0; i < 3; i++) tick();

    // reset mid-drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instW = 32'h7b; reg_a0 = 64'(8'h30 + i);
      tick();
    end
    instW = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 64'(tx_valid), 64'd0);
    chk("t5_level", 64'(fifo_level), 64'd0);
    chk("t5_cnt", 64'(tx_cnt), 64'd0);
    instW = 32'h7b; reg_a0 = 64'h7a;
    tick();
    instW = '0;
    chk("t5_first", 64'(tx_data), 64'h7a);
    tx_ready = 1'b1;
    tick();

    // hold stability, then pointer wrap
    tx_ready = 1'b0;
    instW = 32'h7b; reg_a0 = 64'h68;
    tick();
    instW = 32'h7b; reg_a0 = 64'h69;
    tick();
    instW = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_hold", 64'(tx_data), 64'h68);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instW = 32'h7b; reg_a0 = 64'(8'h40 + i);
      tick();
    end
    instW = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_drained", 64'(fifo_level), 64'd0);

    // tx_cnt wrap
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      instW = 32'h7b; reg_a0 = 64'(8'h55 + i);
      tick();
    end
    instW = '0;
    force dut.tx_cnt_q = 32'hFFFF_FFFE;
    mcnt = 32'hFFFF_FFFE;
    #1;
    release dut.tx_cnt_q;
    tx_ready = 1'b1;
    tick();
    chk("t6_cnt_max", 64'(tx_cnt), 64'hFFFF_FFFF);
    tick();
    chk("t6_cnt_wrap", 64'(tx_cnt), 64'd0);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/putch_tx_ctrl.md
Name: putch_tx_ctrl

Overview:
- Console-output scheduler at the commit end of the pipeline.
- Captures characters from retiring putch instructions (opcode 7'h7b, character in a0[7:0]) and buffers them in a small FIFO.
- Drains the FIFO to a byte-wide valid/ready sink (UART/console model).
- Back-pressures the writeback stage with a stall request when the buffer cannot accept a character, so no output is lost.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
DATA_W, 8, character width in bits
CNT_W, 32, width of the emitted-character counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
stallW  in  1  writeback stage stalled this cycle; instruction not retiring
instW  in  32 (`INST_BUS)  instruction in writeback
reg_a0  in  64 (`REG_BUS)  current a0 value; only [DATA_W-1:0] used
putch_stall  out  1  request to hold writeback: putch in W while FIFO full
tx_valid  out  1  character available to sink
tx_data  out  DATA_W  character at FIFO head
tx_ready  in  1  sink accepts tx_data this cycle
fifo_level  out  log2(DEPTH)+1  current occupancy
tx_cnt  out  CNT_W  characters handed to sink since reset

Behaviour:
- Putch detect: is_putch = (instW[6:0] == `PUTCH_OPCODE).
- push = is_putch & !stallW & !full. pop = tx_valid & tx_ready.
- putch_stall = is_putch & full.
  - Combinational, with no dependence on stallW or tx_ready. This avoids a loop through the hazard unit.
- Full blocks push even when pop is asserted in the same cycle.
  - The stalled putch is accepted in the cycle after the pop.
  - Fixed 1-cycle bubble. Deliberate.
- FIFO is first-word-fall-through.
  - tx_valid = !empty.
  - tx_data = mem[rd_ptr], valid whenever tx_valid=1.
- Push into an empty FIFO: tx_valid rises the next cycle. Latency 1 from retire to sink.
- tx_data/tx_valid must stay stable while tx_valid & !tx_ready. The sink relies on valid/ready stability.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap naturally. Occupancy is held in a separate count register.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push & pop together (only possible when not full and not empty): count unchanged, both pointers advance.
- Pop on empty cannot occur (tx_valid=0). Push on full cannot occur (gated).
- tx_cnt increments on every pop and wraps modulo 2^CNT_W.
- Character captured = reg_a0[DATA_W-1:0]; upper bits are ignored.
- Reset, any cycle including mid-drain:
  - wr_ptr, rd_ptr, count, tx_cnt <= 0.
  - tx_valid=0 from the cycle after rst is sampled.
  - Buffered characters are discarded; FIFO memory is not cleared.
- While rst=1, push is still evaluated but overridden by reset.
- Outputs at reset: tx_valid=0, fifo_level=0, tx_cnt=0. putch_stall=0, since full=0. tx_data is don't-care.
- Character write to $write / simulation console is not done here; the sink model owns it.

Decomposition:
- defines.v: `PUTCH_OPCODE (7'h7b), `INST_BUS, `REG_BUS, `CHAR_W (8).
- One sub-module, sync_fifo_fwft (DEPTH, DATA_W):
  - Ports: push/pop/din/dout/empty/full/level.
  - Reusable for other commit-side buffers.
- The top level holds decode, stall generation and tx_cnt.

Test Plan:
1. Single putch: instW[6:0]=7'h7b, reg_a0=64'h41, stallW=0, tx_ready=1 -> tx_valid=1, tx_data=8'h41 the next cycle for exactly one cycle; tx_cnt=1; fifo_level back to 0.
2. Gating:
   - putch with stallW=1 -> no push, fifo_level=0.
   - Opcode 7'h33 with a0=8'h42 -> ignored.
   - a0=64'hFFFF_FFFF_FFFF_FF42 on a putch -> tx_data=8'h42.
3. Full/back-pressure: tx_ready=0, push 'a'..'h' -> fifo_level=8.
   - 9th putch 'i' -> putch_stall=1, held.
   - Raise tx_ready for 1 cycle -> 'a' popped, putch_stall stays 1 that cycle.
   - Next cycle 'i' is pushed and putch_stall drops.
   - Drain order: a..i.
4. Simultaneous push/pop at level 3 with tx_ready=1 -> level stays 3 across 5 consecutive putches; output order equals input order; tx_cnt increments every cycle.
5. Reset mid-drain: level 5, tx_ready=0, assert rst one cycle -> next cycle tx_valid=0, fifo_level=0, tx_cnt=0; a subsequent putch 'z' emerges as the first character.
6. Hold stability and wrap: tx_ready=0 for 10 cycles -> tx_data constant. Push/pop 20 characters through DEPTH=8 (pointer wrap) -> exact sequence preserved. Also preload tx_cnt near 2^CNT_W-1 via force -> wraps to 0.
